// File: rtl/drvr_bs_endpnt_if.sv
// Bus-side and local-side signal bundle for one driver endpoint of the parallel bus.
// The endpoint uses the slave modport; the arbiter/local logic (or a bench) uses master.
interface drvr_bs_endpnt_if #(
    parameter int bits = 32
);
    // Handshake semantics: FIFO faces, not valid/ready pairs. A data output
    // (D_pop, rx_data) is meaningful only while its FIFO is non-empty
    // (pndng=1, rx_empty=0). A strobe (tx_push, pop, push, rx_pop) acts on
    // each rising edge where it is high. The endpoint never backpressures
    // the bus, so a push into a full RX FIFO is dropped and counted.
    logic            tx_push;
    logic [bits-1:0] tx_data;
    logic            tx_full;
    logic            pndng;
    logic            pop;
    logic [bits-1:0] D_pop;
    logic            push;
    logic [bits-1:0] D_push;
    logic            rx_pop;
    logic [bits-1:0] rx_data;
    logic            rx_empty;
    logic            tx_ovf;
    logic [15:0]     rx_drop_cnt;

    modport master (
        output tx_push, tx_data, pop, push, D_push, rx_pop,
        input  tx_full, pndng, D_pop, rx_data, rx_empty, tx_ovf, rx_drop_cnt
    );

    modport slave (
        input  tx_push, tx_data, pop, push, D_push, rx_pop,
        output tx_full, pndng, D_pop, rx_data, rx_empty, tx_ovf, rx_drop_cnt
    );
endinterface

// File: rtl/drvr_bs_endpnt.sv
// Driver-side bus endpoint: TX FIFO drained by the arbiter, RX FIFO filled by it.
// Optional destination filter on the RX side: define DRVR_BS_ADDR_FILTER_EN.

// First-word-fall-through circular FIFO; head reads as 0 while empty.
module drvr_bs_endpnt_fifo #(
    parameter int bits  = 32,
    parameter int depth = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [bits-1:0] wr_data,
    input  logic            rd,
    output logic [bits-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic            drop
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = (aw+1)'(depth);

    logic [bits-1:0] mem [depth];
    logic [aw-1:0]   rd_ptr;
    logic [aw-1:0]   wr_ptr;
    logic [aw:0]     count;
    logic            do_rd;
    logic            do_wr;

    // A pop frees a slot in the same edge, so a full FIFO still takes a write
    // when popped; a pop on an empty FIFO never happens, even alongside a write.
    always_comb begin
        do_rd = rd && (count != '0);
        do_wr = wr && ((count != full_cnt) || do_rd);
        drop  = wr && !do_wr;
    end

    assign full    = (count == full_cnt);
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + aw'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            count <= count + (aw+1)'(do_wr) - (aw+1)'(do_rd);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= full_cnt);
endmodule

module drvr_bs_endpnt #(
    parameter int         bits      = 32,
    parameter int         depth     = 16,
    parameter int         drvr_id   = 0,
    parameter logic [7:0] broadcast = {8{1'b1}}
) (
    input logic                clk,
    input logic                reset,
    drvr_bs_endpnt_if.slave    bus
);
`ifdef DRVR_BS_ADDR_FILTER_EN
    localparam bit filter_en = 1'b1;
`else
    localparam bit filter_en = 1'b0;
`endif
    localparam logic [7:0] my_id = 8'(drvr_id);

    logic            tx_empty;
    logic            tx_full;
    logic            tx_drop;
    logic [bits-1:0] tx_head;
    logic            rx_empty;
    logic            rx_full;
    logic            rx_drop;
    logic [bits-1:0] rx_head;
    logic [7:0]      dest;
    logic            addr_ok;
    logic            rx_wr;
    logic            rx_drop_evt;
    logic            tx_ovf;
    logic [15:0]     rx_drop_cnt;

    // With the filter compiled out every delivery is addressed to us.
    assign dest        = bus.D_push[bits-1 -: 8];
    assign addr_ok     = !filter_en || (dest == my_id) || (dest == broadcast);
    assign rx_wr       = bus.push && addr_ok;
    assign rx_drop_evt = (bus.push && !addr_ok) || rx_drop;

    drvr_bs_endpnt_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (bus.tx_push),
        .wr_data (bus.tx_data),
        .rd      (bus.pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .drop    (tx_drop)
    );

    drvr_bs_endpnt_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (rx_wr),
        .wr_data (bus.D_push),
        .rd      (bus.rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .drop    (rx_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf      <= 1'b0;
            rx_drop_cnt <= '0;
        end else begin
            if (tx_drop) begin
                tx_ovf <= 1'b1;
            end
            if (rx_drop_evt && (rx_drop_cnt != 16'hFFFF)) begin
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end
        end
    end

    assign bus.tx_full     = tx_full;
    assign bus.pndng       = !tx_empty;
    assign bus.D_pop       = tx_head;
    assign bus.rx_data     = rx_head;
    assign bus.rx_empty    = rx_empty;
    assign bus.tx_ovf      = tx_ovf;
    assign bus.rx_drop_cnt = rx_drop_cnt;

    a_rx_full_seen: assert property (@(posedge clk) disable iff (reset)
        rx_drop |-> rx_full);
endmodule

// File: tb/tb_drvr_bs_endpnt.sv
// Directed bench for drvr_bs_endpnt: drivers push expected packets into queues,
// a negedge monitor pops and compares whenever a FIFO head is consumed.
module tb_drvr_bs_endpnt;
    localparam int bits = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    drvr_bs_endpnt_if #(.bits(bits)) bus ();

    drvr_bs_endpnt #(
        .bits(bits), .depth(16), .drvr_id(3), .broadcast(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [bits-1:0] tx_exp_q[$];
    logic [bits-1:0] rx_exp_q[$];
    logic [bits-1:0] tx_exp_v;
    logic [bits-1:0] rx_exp_v;

    // Monitor: a head is consumed at the next posedge when its pop strobe is high.
    always @(negedge clk) begin
        if (!reset && bus.pop && bus.pndng) begin
            checks++;
            if (tx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h exp none", bus.D_pop);
            end else begin
                tx_exp_v = tx_exp_q.pop_front();
                if (bus.D_pop !== tx_exp_v) begin
                    errors++;
                    $display("FAIL tx_order: got %h exp %h", bus.D_pop, tx_exp_v);
                end
            end
        end
        if (!reset && bus.rx_pop && !bus.rx_empty) begin
            checks++;
            if (rx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got %h exp none", bus.rx_data);
            end else begin
                rx_exp_v = rx_exp_q.pop_front();
                if (bus.rx_data !== rx_exp_v) begin
                    errors++;
                    $display("FAIL rx_order: got %h exp %h", bus.rx_data, rx_exp_v);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", name, act, exp);
        end
    endtask

    task automatic drain_tx(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            if (bus.pndng) begin
                bus.pop = 1'b1;
                got++;
            end else begin
                bus.pop = 1'b0;
            end
            step();
            budget++;
        end
        bus.pop = 1'b0;
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL tx_drain_timeout: got %0d exp %0d", got, n);
        end
    endtask

    task automatic drain_rx(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            if (!bus.rx_empty) begin
                bus.rx_pop = 1'b1;
                got++;
            end else begin
                bus.rx_pop = 1'b0;
            end
            step();
            budget++;
        end
        bus.rx_pop = 1'b0;
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL rx_drain_timeout: got %0d exp %0d", got, n);
        end
    endtask

    initial begin
        int filt_n;
        logic [15:0] filt_drop;

        bus.tx_push = 1'b0;
        bus.tx_data = '0;
        bus.pop     = 1'b0;
        bus.push    = 1'b0;
        bus.D_push  = '0;
        bus.rx_pop  = 1'b0;

        // Reset then idle
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        check("rst_pndng", 32'(bus.pndng), 32'd0);
        check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        check("rst_d_pop", bus.D_pop, 32'h0);
        check("rst_rx_data", bus.rx_data, 32'h0);
        check("rst_tx_full", 32'(bus.tx_full), 32'd0);
        check("rst_tx_ovf", 32'(bus.tx_ovf), 32'd0);
        check("rst_rx_drop", 32'(bus.rx_drop_cnt), 32'd0);

        // Pops while empty are ignored
        bus.pop = 1'b1;
        bus.rx_pop = 1'b1;
        step();
        step();
        bus.pop = 1'b0;
        bus.rx_pop = 1'b0;
        check("empty_pop_pndng", 32'(bus.pndng), 32'd0);
        check("empty_pop_rx_empty", 32'(bus.rx_empty), 32'd1);

        // TX ordering
        bus.tx_push = 1'b1;
        bus.tx_data = 32'h01000011; tx_exp_q.push_back(32'h01000011); step();
        bus.tx_data = 32'h01000022; tx_exp_q.push_back(32'h01000022); step();
        bus.tx_data = 32'h01000033; tx_exp_q.push_back(32'h01000033); step();
        bus.tx_push = 1'b0;
        check("tx_pndng_up", 32'(bus.pndng), 32'd1);
        check("tx_head_first", bus.D_pop, 32'h01000011);
        drain_tx(3);
        check("tx_pndng_down", 32'(bus.pndng), 32'd0);
        check("tx_head_zero", bus.D_pop, 32'h0);

        // Write and pop together while empty: write wins, pop ignored
        bus.tx_push = 1'b1;
        bus.tx_data = 32'h01000044;
        bus.pop = 1'b1;
        tx_exp_q.push_back(32'h01000044);
        step();
        bus.tx_push = 1'b0;
        bus.pop = 1'b0;
        check("tx_wr_pop_empty", 32'(bus.pndng), 32'd1);
        check("tx_wr_pop_empty_head", bus.D_pop, 32'h01000044);
        drain_tx(1);

        // TX full: 17 writes, 17th dropped
        for (int i = 0; i < 17; i++) begin
            bus.tx_push = 1'b1;
            bus.tx_data = 32'h01000100 + 32'(i);
            if (i < 16) tx_exp_q.push_back(32'h01000100 + 32'(i));
            step();
            if (i == 15) begin
                check("tx_full_at_16", 32'(bus.tx_full), 32'd1);
                check("tx_ovf_before", 32'(bus.tx_ovf), 32'd0);
            end
        end
        bus.tx_push = 1'b0;
        check("tx_ovf_set", 32'(bus.tx_ovf), 32'd1);
        drain_tx(16);
        check("tx_full_drained", 32'(bus.pndng), 32'd0);
        check("tx_ovf_sticky", 32'(bus.tx_ovf), 32'd1);

        // RX full and simultaneous push/pop
        for (int i = 0; i < 16; i++) begin
            bus.push = 1'b1;
            bus.D_push = 32'h03000200 + 32'(i);
            rx_exp_q.push_back(32'h03000200 + 32'(i));
            step();
        end
        bus.push = 1'b0;
        check("rx_head_after_fill", bus.rx_data, 32'h03000200);
        bus.push = 1'b1;
        bus.D_push = 32'h03000299;
        bus.rx_pop = 1'b1;
        rx_exp_q.push_back(32'h03000299);
        step();
        bus.push = 1'b0;
        bus.rx_pop = 1'b0;
        check("rx_full_wr_pop_drop", 32'(bus.rx_drop_cnt), 32'd0);
        check("rx_full_wr_pop_head", bus.rx_data, 32'h03000201);
        bus.push = 1'b1;
        bus.D_push = 32'h030002AA;
        step();
        bus.push = 1'b0;
        check("rx_full_drop", 32'(bus.rx_drop_cnt), 32'd1);
        drain_rx(16);
        check("rx_drained", 32'(bus.rx_empty), 32'd1);

        // Wrap-around stream with concurrent pops
        bus.rx_pop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.push = 1'b1;
            bus.D_push = 32'h03000400 + 32'(i);
            rx_exp_q.push_back(32'h03000400 + 32'(i));
            step();
        end
        bus.push = 1'b0;
        step();
        bus.rx_pop = 1'b0;
        check("stream_empty", 32'(bus.rx_empty), 32'd1);
        check("stream_no_drop", 32'(bus.rx_drop_cnt), 32'd1);
        check("stream_all_seen", 32'(rx_exp_q.size()), 32'd0);

        // Reset mid-transfer discards queued data and counters
        bus.tx_push = 1'b1;
        bus.tx_data = 32'h01000555; step();
        bus.tx_data = 32'h01000666;
        bus.push = 1'b1;
        bus.D_push = 32'h03000777;
        step();
        bus.tx_push = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.pop = 1'b0;
        step();
        check("mid_rst_pndng", 32'(bus.pndng), 32'd0);
        check("mid_rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        check("mid_rst_d_pop", bus.D_pop, 32'h0);
        check("mid_rst_tx_ovf", 32'(bus.tx_ovf), 32'd0);
        check("mid_rst_rx_drop", 32'(bus.rx_drop_cnt), 32'd0);

        // Destination filter (drvr_id=3, broadcast=FF)
        bus.push = 1'b1;
        bus.D_push = 32'h03000301; rx_exp_q.push_back(32'h03000301); step();
        bus.D_push = 32'h05000302;
`ifdef DRVR_BS_ADDR_FILTER_EN
        filt_n = 2;
        filt_drop = 16'd1;
`else
        rx_exp_q.push_back(32'h05000302);
        filt_n = 3;
        filt_drop = 16'd0;
`endif
        step();
        bus.D_push = 32'hFF000303; rx_exp_q.push_back(32'hFF000303); step();
        bus.push = 1'b0;
        check("filter_drop_cnt", 32'(bus.rx_drop_cnt), 32'(filt_drop));
        drain_rx(filt_n);
        check("filter_rx_empty", 32'(bus.rx_empty), 32'd1);

        step();
        check("tx_queue_left", 32'(tx_exp_q.size()), 32'd0);
        check("rx_queue_left", 32'(rx_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
